// File: rtl/spinnaker_link_pkg.sv
// Purpose: shared 2-of-7 code points, packet lengths and FSM states for the link receiver.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package spinnaker_link_pkg;

   // Data symbols: the two wires that toggle for each nibble value
   localparam logic [6:0] CODE_0 = 7'h11;
   localparam logic [6:0] CODE_1 = 7'h12;
   localparam logic [6:0] CODE_2 = 7'h14;
   localparam logic [6:0] CODE_3 = 7'h18;
   localparam logic [6:0] CODE_4 = 7'h21;
   localparam logic [6:0] CODE_5 = 7'h22;
   localparam logic [6:0] CODE_6 = 7'h24;
   localparam logic [6:0] CODE_7 = 7'h28;
   localparam logic [6:0] CODE_8 = 7'h41;
   localparam logic [6:0] CODE_9 = 7'h42;
   localparam logic [6:0] CODE_A = 7'h44;
   localparam logic [6:0] CODE_B = 7'h48;
   localparam logic [6:0] CODE_C = 7'h03;
   localparam logic [6:0] CODE_D = 7'h06;
   localparam logic [6:0] CODE_E = 7'h0C;
   localparam logic [6:0] CODE_F = 7'h09;
   localparam logic [6:0] EOP_CODE = 7'h60;

   // Nibble counts for a 40-bit and a 72-bit packet
   localparam logic [4:0] SHORT_NIBBLES = 5'd10;
   localparam logic [4:0] LONG_NIBBLES  = 5'd18;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DELIVER,
      DROP
   } state_t;

endpackage

// File: rtl/spinnaker_link_2of7_decoder.sv
// Purpose: classify a 7-bit transition vector as data nibble, EOP, error or nothing.
// Latency: combinational.
// Backpressure: none; the caller decides when a symbol is consumed.
module spinnaker_link_2of7_decoder
   import spinnaker_link_pkg::*;
(
   input  logic [6:0] d,
   output logic [3:0] nibble,
   output logic       is_data,
   output logic       is_eop,
   output logic       is_error
);

   // Fewer than two changed wires means the symbol is still in flight
   always_comb begin
      nibble   = 4'h0;
      is_data  = 1'b0;
      is_eop   = 1'b0;
      is_error = 1'b0;
      if ($countones(d) >= 3) begin
         is_error = 1'b1;
      end else if ($countones(d) == 2) begin
         is_data = 1'b1;
         case (d)
            CODE_0:   nibble = 4'h0;
            CODE_1:   nibble = 4'h1;
            CODE_2:   nibble = 4'h2;
            CODE_3:   nibble = 4'h3;
            CODE_4:   nibble = 4'h4;
            CODE_5:   nibble = 4'h5;
            CODE_6:   nibble = 4'h6;
            CODE_7:   nibble = 4'h7;
            CODE_8:   nibble = 4'h8;
            CODE_9:   nibble = 4'h9;
            CODE_A:   nibble = 4'hA;
            CODE_B:   nibble = 4'hB;
            CODE_C:   nibble = 4'hC;
            CODE_D:   nibble = 4'hD;
            CODE_E:   nibble = 4'hE;
            CODE_F:   nibble = 4'hF;
            EOP_CODE: begin
               is_data = 1'b0;
               is_eop  = 1'b1;
            end
            default: begin
               is_data  = 1'b0;
               is_error = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/spinnaker_link_packet_consumer.sv
// Purpose: SpiNNaker 2-of-7 NRZ link receiver; assembles 40/72-bit packets for the bridge FIFO.
// Latency: ack toggles SYNC_STAGES+1 edges after a pin change; fifo_write one edge after the EOP is seen.
// Backpressure: fifo_full holds the EOP unacked (stalling the link); SPINNAKER_LINK_PARITY_CHECK_EN adds parity_err.
module spinnaker_link_packet_consumer
   import spinnaker_link_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  code2of7,
   output logic        ack,
   input  logic        fifo_full,
   output logic        fifo_write,
   output logic [71:0] packet
`ifdef SPINNAKER_LINK_PARITY_CHECK_EN
   ,
   output logic        parity_err
`endif
);

   logic [6:0]  sync_q [SYNC_STAGES];
   logic [6:0]  sync;
   logic [6:0]  old_q;
   logic [6:0]  d;
   logic [3:0]  nib;
   logic        is_data;
   logic        is_eop;
   logic        is_error;
   logic [71:0] asm_q;
   logic [4:0]  cnt_q;
   logic [4:0]  exp_nibbles;
   state_t      state_q;
   state_t      state_nxt;
   logic        accept;
   logic        start;
   logic        store;
   logic        deliver;
   logic        perr;

   // Bring the asynchronous wires into clk
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= code2of7;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync        = sync_q[SYNC_STAGES-1];
   assign d           = sync ^ old_q;
   // Header bit 1 selects a long packet; only meaningful once nibble 0 is stored
   assign exp_nibbles = asm_q[1] ? LONG_NIBBLES : SHORT_NIBBLES;

   spinnaker_link_2of7_decoder u_decoder (
      .d        (d),
      .nibble   (nib),
      .is_data  (is_data),
      .is_eop   (is_eop),
      .is_error (is_error)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_nxt;
   end

   // Next state and per-cycle datapath controls; at most one symbol consumed per cycle
   always_comb begin
      state_nxt = state_q;
      accept    = 1'b0;
      start     = 1'b0;
      store     = 1'b0;
      deliver   = 1'b0;
      perr      = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_error) begin
               accept    = 1'b1;
               state_nxt = DROP;
            end else if (is_data) begin
               accept    = 1'b1;
               start     = 1'b1;
               state_nxt = RECV;
            end else if (is_eop) begin
               accept    = 1'b1;
            end
         end
         RECV: begin
            if (is_error) begin
               accept    = 1'b1;
               state_nxt = DROP;
            end else if (is_data) begin
               accept = 1'b1;
               if (cnt_q == exp_nibbles) state_nxt = DROP;
               else                      store     = 1'b1;
            end else if (is_eop) begin
               // A correctly placed EOP is left unacked until the FIFO takes the packet
               if (cnt_q == exp_nibbles) begin
                  state_nxt = DELIVER;
               end else begin
                  accept    = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         DELIVER: begin
`ifdef SPINNAKER_LINK_PARITY_CHECK_EN
            if (!(^asm_q)) begin
               accept    = 1'b1;
               perr      = 1'b1;
               state_nxt = IDLE;
            end else
`endif
            if (!fifo_full) begin
               accept    = 1'b1;
               deliver   = 1'b1;
               state_nxt = IDLE;
            end
         end
         DROP: begin
            if (is_data || is_eop || is_error) begin
               accept = 1'b1;
               if (is_eop) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Symbol acknowledge, packet assembly and delivery registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         old_q      <= '0;
         ack        <= 1'b0;
         asm_q      <= '0;
         cnt_q      <= '0;
         fifo_write <= 1'b0;
         packet     <= '0;
      end else begin
         if (accept) begin
            old_q <= sync;
            ack   <= ~ack;
         end
         if (start) begin
            asm_q <= {68'd0, nib};
            cnt_q <= 5'd1;
         end else if (store) begin
            asm_q[{cnt_q, 2'b00} +: 4] <= nib;
            cnt_q                      <= cnt_q + 5'd1;
         end
         fifo_write <= deliver;
         if (deliver) packet <= asm_q;
      end
   end

`ifdef SPINNAKER_LINK_PARITY_CHECK_EN
   // One-cycle pulse when a completed packet has even parity
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) parity_err <= 1'b0;
      else          parity_err <= perr;
   end
`endif

endmodule

// File: tb/tb_spinnaker_link_packet_consumer.sv
// Purpose: directed self-checking bench for the 2-of-7 link packet consumer.
// Latency: expects ack SYNC_STAGES+1 edges after a pin change, delivery one edge after EOP.
// Backpressure: exercises fifo_full holding the EOP; parity test only with SPINNAKER_LINK_PARITY_CHECK_EN.
module tb_spinnaker_link_packet_consumer;

   localparam int SYNC_STAGES = 2;

   logic        clk;
   logic        reset_n;
   logic [6:0]  code2of7;
   logic        ack;
   logic        fifo_full;
   logic        fifo_write;
   logic [71:0] packet;
`ifdef SPINNAKER_LINK_PARITY_CHECK_EN
   logic        parity_err;
`endif

   int          n_checks;
   int          n_fail;
   int          ack_toggles;
   int          wr_count;
   int          perr_count;
   int          last_lat;
   logic        ack_last;
   logic [71:0] last_pkt;

   spinnaker_link_packet_consumer #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .code2of7   (code2of7),
      .ack        (ack),
      .fifo_full  (fifo_full),
      .fifo_write (fifo_write),
      .packet     (packet)
`ifdef SPINNAKER_LINK_PARITY_CHECK_EN
      ,
      .parity_err (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe ack toggles, writes and parity pulses away from the active edge
   always @(negedge clk) begin
      if (ack !== ack_last) ack_toggles++;
      ack_last = ack;
      if (fifo_write === 1'b1) begin
         wr_count++;
         last_pkt = packet;
      end
`ifdef SPINNAKER_LINK_PARITY_CHECK_EN
      if (parity_err === 1'b1) perr_count++;
`endif
   end

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: enc = 7'h11;  4'h1: enc = 7'h12;  4'h2: enc = 7'h14;  4'h3: enc = 7'h18;
         4'h4: enc = 7'h21;  4'h5: enc = 7'h22;  4'h6: enc = 7'h24;  4'h7: enc = 7'h28;
         4'h8: enc = 7'h41;  4'h9: enc = 7'h42;  4'hA: enc = 7'h44;  4'hB: enc = 7'h48;
         4'hC: enc = 7'h03;  4'hD: enc = 7'h06;  4'hE: enc = 7'h0C;  default: enc = 7'h09;
      endcase
   endfunction

   // Toggle the given wires and wait (bounded) for the ack to toggle
   task automatic send_sym(input logic [6:0] d, input string name);
      logic a0;
      int   cyc;
      @(negedge clk);
      a0       = ack;
      code2of7 = code2of7 ^ d;
      cyc      = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (ack === a0 && cyc < 40);
      last_lat = cyc;
      n_checks++;
      if (ack === a0) begin
         n_fail++;
         $display("FAIL %s: ack did not toggle within %0d cycles (ack=%b)", name, cyc, ack);
      end
   endtask

   task automatic send_packet(input logic [71:0] p, input int n, input string name);
      for (int i = 0; i < n; i++) send_sym(enc(p[4*i +: 4]), name);
      send_sym(7'h60, name);
   endtask

   task automatic test_reset;
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
      n_checks++;
      if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_write: got %b want 0", fifo_write); end
      n_checks++;
      if (packet !== 72'h0) begin n_fail++; $display("FAIL reset_packet: got %h want 0", packet); end
   endtask

   task automatic test_short;
      int t0, w0;
      t0 = ack_toggles;
      w0 = wr_count;
      send_sym(enc(4'h1), "short_n0");
      n_checks++;
      if (last_lat != SYNC_STAGES + 1) begin
         n_fail++;
         $display("FAIL short_latency: got %0d cycles want %0d", last_lat, SYNC_STAGES + 1);
      end
      for (int i = 1; i < 10; i++) send_sym(enc(4'h0), "short_n");
      send_sym(7'h60, "short_eop");
      repeat (2) @(negedge clk);
      n_checks++;
      if (ack_toggles - t0 != 11) begin n_fail++; $display("FAIL short_acks: got %0d want 11", ack_toggles - t0); end
      n_checks++;
      if (wr_count - w0 != 1) begin n_fail++; $display("FAIL short_writes: got %0d want 1", wr_count - w0); end
      n_checks++;
      if (last_pkt !== 72'h01) begin n_fail++; $display("FAIL short_packet: got %h want %h", last_pkt, 72'h01); end
   endtask

   task automatic test_long;
      int w0;
      logic [71:0] exp;
      exp = {32'hDEADBEEF, 32'h12345678, 8'h03};
      w0  = wr_count;
      send_packet(exp, 18, "long");
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_count - w0 != 1) begin n_fail++; $display("FAIL long_writes: got %0d want 1", wr_count - w0); end
      n_checks++;
      if (last_pkt !== exp) begin n_fail++; $display("FAIL long_packet: got %h want %h", last_pkt, exp); end
   endtask

   task automatic test_fifo_full;
      logic [71:0] exp;
      logic        a0;
      logic        bad_ack, bad_wr;
      exp       = 72'h0000000000_00001101;
      fifo_full = 1'b1;
      for (int i = 0; i < 10; i++) send_sym(enc(exp[4*i +: 4]), "full_n");
      @(negedge clk);
      a0       = ack;
      code2of7 = code2of7 ^ 7'h60;
      bad_ack  = 1'b0;
      bad_wr   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack !== a0) bad_ack = 1'b1;
         if (fifo_write !== 1'b0) bad_wr = 1'b1;
      end
      n_checks++;
      if (bad_ack) begin n_fail++; $display("FAIL full_hold_ack: ack toggled got %b want %b", ack, a0); end
      n_checks++;
      if (bad_wr) begin n_fail++; $display("FAIL full_hold_write: write seen got 1 want 0"); end
      fifo_full = 1'b0;
      @(negedge clk);
      n_checks++;
      if (fifo_write !== 1'b1) begin n_fail++; $display("FAIL full_release_write: got %b want 1", fifo_write); end
      n_checks++;
      if (ack === a0) begin n_fail++; $display("FAIL full_release_ack: got %b want %b", ack, ~a0); end
      n_checks++;
      if (packet !== exp) begin n_fail++; $display("FAIL full_release_packet: got %h want %h", packet, exp); end
      @(negedge clk);
      n_checks++;
      if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL full_write_pulse: got %b want 0", fifo_write); end
   endtask

   task automatic test_early_eop;
      int w0;
      logic [71:0] exp;
      w0 = wr_count;
      for (int i = 0; i < 5; i++) send_sym(enc(4'h7), "early_n");
      send_sym(7'h60, "early_eop");
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_count != w0) begin n_fail++; $display("FAIL early_no_write: got %0d want %0d", wr_count, w0); end
      exp = 72'h0000000000_0000CAFE81;
      send_packet(exp, 10, "early_next");
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_count - w0 != 1) begin n_fail++; $display("FAIL early_next_writes: got %0d want 1", wr_count - w0); end
      n_checks++;
      if (last_pkt !== exp) begin n_fail++; $display("FAIL early_next_packet: got %h want %h", last_pkt, exp); end
   endtask

   task automatic test_idle_eop;
      int w0;
      w0 = wr_count;
      send_sym(7'h60, "idle_eop");
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_count != w0) begin n_fail++; $display("FAIL idle_eop_write: got %0d want %0d", wr_count, w0); end
   endtask

   task automatic test_error_drop;
      int w0;
      logic [71:0] exp;
      w0 = wr_count;
      for (int i = 0; i < 3; i++) send_sym(enc(4'h5), "err_n");
      send_sym(7'h07, "err_3wire");
      send_sym(enc(4'h2), "drop_n");
      send_sym(enc(4'h9), "drop_n");
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_count != w0) begin n_fail++; $display("FAIL drop_no_write: got %0d want %0d", wr_count, w0); end
      send_sym(7'h60, "drop_eop");
      repeat (2) @(negedge clk);
      n_checks++;
      if (wr_count != w0) begin n_fail++; $display("FAIL drop_eop_write: got %0d want %0d", wr_count, w0); end
      exp = 72'h0000000000_0000000301;
      send_packet(exp, 10, "drop_next");
      repeat (2) @(negedge clk);
      n_checks++;
      if (last_pkt !== exp || wr_count - w0 != 1) begin
         n_fail++;
         $display("FAIL drop_next_packet: got %h (%0d writes) want %h (1 write)", last_pkt, wr_count - w0, exp);
      end
   endtask

`ifdef SPINNAKER_LINK_PARITY_CHECK_EN
   task automatic test_parity;
      int w0, p0;
      w0 = wr_count;
      p0 = perr_count;
      send_packet(72'h0, 10, "parity");
      repeat (2) @(negedge clk);
      n_checks++;
      if (perr_count - p0 != 1) begin n_fail++; $display("FAIL parity_pulse: got %0d want 1", perr_count - p0); end
      n_checks++;
      if (wr_count != w0) begin n_fail++; $display("FAIL parity_no_write: got %0d want %0d", wr_count, w0); end
   endtask
`endif

   task automatic test_reset_mid;
      logic [71:0] exp;
      for (int i = 0; i < 4; i++) send_sym(enc(4'h3), "mid_n");
      @(negedge clk);
      reset_n  = 1'b0;
      code2of7 = 7'h00;
      #1;
      n_checks++;
      if (ack !== 1'b0 || fifo_write !== 1'b0 || packet !== 72'h0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got ack=%b wr=%b pkt=%h want 0/0/0", ack, fifo_write, packet);
      end
`ifdef SPINNAKER_LINK_PARITY_CHECK_EN
      n_checks++;
      if (parity_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_parity_err: got %b want 0", parity_err); end
`endif
      @(negedge clk);
      reset_n = 1'b1;
      ack_last = ack;
      exp = 72'h0000000000_0000CAFE81;
      send_packet(exp, 10, "after_reset");
      repeat (2) @(negedge clk);
      n_checks++;
      if (last_pkt !== exp) begin n_fail++; $display("FAIL after_reset_packet: got %h want %h", last_pkt, exp); end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      ack_toggles = 0;
      wr_count    = 0;
      perr_count  = 0;
      last_lat    = 0;
      ack_last    = 1'b0;
      last_pkt    = '0;
      reset_n     = 1'b0;
      code2of7    = 7'h00;
      fifo_full   = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      reset_n = 1'b1;
      @(negedge clk);
      test_short;
      test_long;
      test_fifo_full;
      test_early_eop;
      test_idle_eop;
      test_error_drop;
`ifdef SPINNAKER_LINK_PARITY_CHECK_EN
      test_parity;
`endif
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
